// File: rtl/hdmi_packet_pkg.sv
// Shared sizes, BCH constants and FSM state type for the HDMI data-island packet assembler.
// Pure declarations: no logic, no latency.
package hdmi_packet_pkg;

   localparam int HEADER_BITS   = 24;
   localparam int SUB_BITS      = 56;
   localparam int ECC_BITS      = 8;
   localparam int PACKET_CLOCKS = 32;
   localparam int NUM_SUBS      = 4;
   localparam int DATA_W        = 1 + 2 * NUM_SUBS;

   localparam logic [ECC_BITS-1:0] BCH_POLY = 8'h83;

   typedef enum logic [1:0] {
      IDLE,
      LOADED,
      SENDING
   } state_e;

   // One LSB-first step of the 1+x^6+x^7+x^8 BCH remainder.
   function automatic logic [ECC_BITS-1:0] bch_step(input logic [ECC_BITS-1:0] ecc,
                                                    input logic              b);
      logic fb;
      fb = ecc[0] ^ b;
      return (ecc >> 1) ^ (fb ? BCH_POLY : '0);
   endfunction

endpackage

// File: rtl/bch_ecc.sv
// Serial BCH accumulator absorbing BITS_PER_CYCLE bits (bit 0 first) on start or advance.
// start restarts the remainder from zero and absorbs in the same cycle; result valid the cycle after.
module bch_ecc
   import hdmi_packet_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                      clk_pixel,
   input  logic                      reset,
   input  logic                      start_i,
   input  logic                      advance_i,
   input  logic [BITS_PER_CYCLE-1:0] bits_i,
   output logic [ECC_BITS-1:0]       ecc_o
);

   logic [ECC_BITS-1:0] ecc_q;
   logic [ECC_BITS-1:0] ecc_d;

   always_comb begin
      ecc_d = start_i ? '0 : ecc_q;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         ecc_d = bch_step(ecc_d, bits_i[i]);
      end
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         ecc_q <= '0;
      end else if (start_i || advance_i) begin
         ecc_q <= ecc_d;
      end
   end

   assign ecc_o = ecc_q;

endmodule

// File: rtl/packet_assembler.sv
// Single-buffer HDMI packet serialiser: 32 clocks of header/subpacket bits with BCH ECC appended.
// First bit one cycle after LOADED sees island_active; dropping island_active aborts the packet.
module packet_assembler
   import hdmi_packet_pkg::*;
(
   input  logic                   clk_pixel,
   input  logic                   reset,
   input  logic [HEADER_BITS-1:0] header,
   input  logic [SUB_BITS-1:0]    sub0,
   input  logic [SUB_BITS-1:0]    sub1,
   input  logic [SUB_BITS-1:0]    sub2,
   input  logic [SUB_BITS-1:0]    sub3,
   input  logic                   packet_valid,
   output logic                   packet_ready,
   input  logic                   island_active,
   output logic [DATA_W-1:0]      packet_data,
   output logic                   packet_done,
   output logic                   packet_abort
);

   localparam int IDX_W = $clog2(PACKET_CLOCKS);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(PACKET_CLOCKS - 1);
   localparam logic [IDX_W-1:0] HDR_ECC_IDX = IDX_W'(HEADER_BITS);
   localparam logic [IDX_W-1:0] SUB_ECC_IDX = IDX_W'(SUB_BITS / 2);

   state_e                            state_q;
   logic [IDX_W-1:0]                  n_q;
   logic [HEADER_BITS-1:0]            header_q;
   logic [NUM_SUBS-1:0][SUB_BITS-1:0] sub_q;
   logic [DATA_W-1:0]                 data_q;
   logic                              done_q;
   logic                              abort_q;

   logic [IDX_W-1:0]                  idx_d;
   logic [DATA_W-1:0]                 data_d;
   logic [2:0]                        hdr_off;
   logic [1:0]                        sub_off;
   logic                              hdr_bit;
   logic [NUM_SUBS-1:0][1:0]          sub_pair;
   logic                              ecc_start;
   logic                              ecc_adv;
   logic                              hdr_adv;
   logic                              sub_adv;
   logic [ECC_BITS-1:0]               hdr_ecc;
   logic [NUM_SUBS-1:0][ECC_BITS-1:0] sub_ecc;

   // idx_d is the index whose bits get registered onto packet_data at the coming edge.
   assign idx_d     = (state_q == SENDING) ? n_q + IDX_W'(1) : '0;
   assign ecc_start = (state_q == LOADED) && island_active;
   assign ecc_adv   = (state_q == SENDING) && island_active && (n_q != LAST_IDX);
   assign hdr_adv   = ecc_adv && (idx_d < HDR_ECC_IDX);
   assign sub_adv   = ecc_adv && (idx_d < SUB_ECC_IDX);

   always_comb begin
      hdr_off = 3'(idx_d - HDR_ECC_IDX);
      sub_off = 2'(idx_d - SUB_ECC_IDX);
      hdr_bit = (idx_d < HDR_ECC_IDX) ? header_q[idx_d] : hdr_ecc[hdr_off];
      for (int k = 0; k < NUM_SUBS; k++) begin
         sub_pair[k] = (idx_d < SUB_ECC_IDX) ? sub_q[k][{idx_d, 1'b0} +: 2]
                                             : sub_ecc[k][{sub_off, 1'b0} +: 2];
      end
   end

   always_comb begin
      data_d    = '0;
      data_d[0] = hdr_bit;
      for (int k = 0; k < NUM_SUBS; k++) begin
         data_d[1 + k] = sub_pair[k][0];
         data_d[5 + k] = sub_pair[k][1];
      end
   end

   // The accumulators absorb exactly the bits being registered, so the
   // remainder is complete and frozen by the time its first ECC bit is needed.
   bch_ecc #(
      .BITS_PER_CYCLE(1)
   ) u_hdr_ecc (
      .clk_pixel(clk_pixel),
      .reset    (reset),
      .start_i  (ecc_start),
      .advance_i(hdr_adv),
      .bits_i   (hdr_bit),
      .ecc_o    (hdr_ecc)
   );

   for (genvar k = 0; k < NUM_SUBS; k++) begin : g_sub_ecc
      bch_ecc #(
         .BITS_PER_CYCLE(2)
      ) u_sub_ecc (
         .clk_pixel(clk_pixel),
         .reset    (reset),
         .start_i  (ecc_start),
         .advance_i(sub_adv),
         .bits_i   (sub_pair[k]),
         .ecc_o    (sub_ecc[k])
      );
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         n_q      <= '0;
         header_q <= '0;
         sub_q    <= '0;
         data_q   <= '0;
         done_q   <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         abort_q <= 1'b0;
         case (state_q)
            IDLE: begin
               data_q <= '0;
               if (packet_valid) begin
                  header_q <= header;
                  sub_q    <= {sub3, sub2, sub1, sub0};
                  state_q  <= LOADED;
               end
            end
            LOADED: begin
               if (island_active) begin
                  state_q <= SENDING;
                  n_q     <= '0;
                  data_q  <= data_d;
               end else begin
                  data_q  <= '0;
               end
            end
            SENDING: begin
               if (!island_active) begin
                  state_q <= IDLE;
                  n_q     <= '0;
                  data_q  <= '0;
                  abort_q <= 1'b1;
               end else if (n_q == LAST_IDX) begin
                  state_q <= IDLE;
                  n_q     <= '0;
                  data_q  <= '0;
                  done_q  <= 1'b1;
               end else begin
                  n_q     <= idx_d;
                  data_q  <= data_d;
               end
            end
            default: begin
               state_q <= IDLE;
               n_q     <= '0;
               data_q  <= '0;
            end
         endcase
      end
   end

   assign packet_ready = (state_q == IDLE);
   assign packet_data  = data_q;
   assign packet_done  = done_q;
   assign packet_abort = abort_q;

endmodule

// File: tb/tb_packet_assembler.sv
// Directed bench for packet_assembler: full packets, ECC tail, abort, ignored reload, mid-packet reset.
module tb_packet_assembler;

   localparam int STOP_NONE  = 0;
   localparam int STOP_ABORT = 1;
   localparam int STOP_RESET = 2;

   logic        clk_pixel = 1'b0;
   logic        reset;
   logic [23:0] header;
   logic [55:0] sub0, sub1, sub2, sub3;
   logic        packet_valid;
   logic        packet_ready;
   logic        island_active;
   logic [8:0]  packet_data;
   logic        packet_done;
   logic        packet_abort;

   int n_cmp = 0;
   int n_bad = 0;

   packet_assembler dut (
      .clk_pixel    (clk_pixel),
      .reset        (reset),
      .header       (header),
      .sub0         (sub0),
      .sub1         (sub1),
      .sub2         (sub2),
      .sub3         (sub3),
      .packet_valid (packet_valid),
      .packet_ready (packet_ready),
      .island_active(island_active),
      .packet_data  (packet_data),
      .packet_done  (packet_done),
      .packet_abort (packet_abort)
   );

   always #5 clk_pixel = ~clk_pixel;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_pixel);
      #1;
   endtask

   // Reference BCH remainder: divide by 1+x^6+x^7+x^8, LSB first.
   function automatic logic [7:0] bch_ref(input logic [7:0] e, input logic b);
      logic [7:0] r;
      r = {1'b0, e[7:1]};
      if (e[0] ^ b) r = r ^ 8'h83;
      return r;
   endfunction

   task automatic run_packet(input logic [23:0] h,
                             input logic [55:0] s0, input logic [55:0] s1,
                             input logic [55:0] s2, input logic [55:0] s3,
                             input int hold, input int stop_at, input int stop_kind,
                             input bit inject);
      logic [8:0]  expv [32];
      logic [55:0] s    [4];
      logic [7:0]  se   [4];
      logic [7:0]  he;
      logic [55:0] t56;
      logic [23:0] t24;
      logic [7:0]  t8;
      logic [8:0]  v;

      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      he = '0;
      for (int i = 0; i < 24; i++) begin
         t24 = h >> i;
         he  = bch_ref(he, t24[0]);
      end
      for (int k = 0; k < 4; k++) begin
         se[k] = '0;
         for (int i = 0; i < 56; i++) begin
            t56   = s[k] >> i;
            se[k] = bch_ref(se[k], t56[0]);
         end
      end
      for (int n = 0; n < 32; n++) begin
         v = '0;
         if (n < 24) begin
            t24 = h >> n;
            v[0] = t24[0];
         end else begin
            t8 = he >> (n - 24);
            v[0] = t8[0];
         end
         for (int k = 0; k < 4; k++) begin
            if (n < 28) begin
               t56 = s[k] >> (2 * n);
               v[1 + k] = t56[0];
               v[5 + k] = t56[1];
            end else begin
               t8 = se[k] >> (2 * (n - 28));
               v[1 + k] = t8[0];
               v[5 + k] = t8[1];
            end
         end
         expv[n] = v;
      end

      header = h; sub0 = s0; sub1 = s1; sub2 = s2; sub3 = s3;
      packet_valid = 1'b1;
      tick();
      packet_valid = 1'b0;
      check_eq("load_ready", packet_ready, 1'b0);
      for (int i = 0; i < hold; i++) begin
         tick();
         check_eq("loaded_data", packet_data, 9'h0);
         check_eq("loaded_ready", packet_ready, 1'b0);
      end

      island_active = 1'b1;
      for (int n = 0; n < 32; n++) begin
         tick();
         check_eq($sformatf("bit%0d", n), packet_data, expv[n]);
         if (n == 0) check_eq("busy_ready", packet_ready, 1'b0);
         if (inject && n == 5) begin
            packet_valid = 1'b1;
            header = ~h; sub0 = ~s0; sub1 = ~s1; sub2 = ~s2; sub3 = ~s3;
         end
         if (inject && n == 6) packet_valid = 1'b0;
         if (n == stop_at && stop_kind == STOP_ABORT) begin
            island_active = 1'b0;
            tick();
            check_eq("abort_data", packet_data, 9'h0);
            check_eq("abort_pulse", packet_abort, 1'b1);
            check_eq("abort_ready", packet_ready, 1'b1);
            check_eq("abort_nodone", packet_done, 1'b0);
            tick();
            check_eq("abort_clear", packet_abort, 1'b0);
            return;
         end
         if (n == stop_at && stop_kind == STOP_RESET) begin
            reset = 1'b1;
            #1;
            check_eq("rst_data", packet_data, 9'h0);
            check_eq("rst_done", packet_done, 1'b0);
            check_eq("rst_abort", packet_abort, 1'b0);
            island_active = 1'b0;
            tick();
            check_eq("rst_hold_abort", packet_abort, 1'b0);
            reset = 1'b0;
            tick();
            check_eq("rst_ready", packet_ready, 1'b1);
            check_eq("rst_data2", packet_data, 9'h0);
            check_eq("rst_done2", packet_done, 1'b0);
            check_eq("rst_abort2", packet_abort, 1'b0);
            return;
         end
      end
      tick();
      check_eq("done_pulse", packet_done, 1'b1);
      check_eq("done_data", packet_data, 9'h0);
      check_eq("done_ready", packet_ready, 1'b1);
      check_eq("done_noabort", packet_abort, 1'b0);
      island_active = 1'b0;
      tick();
      check_eq("done_clear", packet_done, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      header = '0; sub0 = '0; sub1 = '0; sub2 = '0; sub3 = '0;
      packet_valid = 1'b0;
      island_active = 1'b0;
      repeat (2) @(posedge clk_pixel);
      #1;
      check_eq("reset_ready", packet_ready, 1'b1);
      check_eq("reset_data", packet_data, 9'h0);
      check_eq("reset_done", packet_done, 1'b0);
      check_eq("reset_abort", packet_abort, 1'b0);
      reset = 1'b0;
      tick();
      check_eq("idle_ready", packet_ready, 1'b1);

      run_packet(24'h000000, 56'h0, 56'h0, 56'h0, 56'h0, 0, -1, STOP_NONE, 1'b0);
      run_packet(24'h000001, 56'h0, 56'h0, 56'h0, 56'h0, 0, -1, STOP_NONE, 1'b0);
      run_packet(24'h000000, 56'h0, 56'h0, 56'h3, 56'h0, 2, -1, STOP_NONE, 1'b0);
      run_packet(24'hA5C30F, 56'h0123456789ABCD, 56'hFEDCBA98765432,
                 56'h00FF00FF00FF00, 56'h80000000000001, 0, -1, STOP_NONE, 1'b0);
      run_packet(24'h123456, 56'h11111111111111, 56'h22222222222222,
                 56'h33333333333333, 56'h44444444444444, 0, 10, STOP_ABORT, 1'b0);
      run_packet(24'h00C0DE, 56'hDEADBEEFCAFE01, 56'h0, 56'h55AA55AA55AA55, 56'h7, 1, -1, STOP_NONE, 1'b0);
      run_packet(24'h5A5A5A, 56'hA5A5A5A5A5A5A5, 56'h0F0F0F0F0F0F0F,
                 56'h1, 56'hF000000000000F, 0, -1, STOP_NONE, 1'b1);
      run_packet(24'hFFFFFF, 56'hFFFFFFFFFFFFFF, 56'hFFFFFFFFFFFFFF,
                 56'hFFFFFFFFFFFFFF, 56'hFFFFFFFFFFFFFF, 0, 15, STOP_RESET, 1'b0);
      run_packet(24'h000080, 56'h00000000000100, 56'h0, 56'h0, 56'h0, 0, -1, STOP_NONE, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
